// File: rtl/shift_pkg.sv
// Shared op codes and FSM state encoding for the iterative shifter.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASL = 2'b10;
  localparam logic [1:0] SH_ASR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift of WIDTH bits; also reports the bit pushed out.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             shifted_out
);

  // One step of the selected operation; ASL behaves exactly like LSL.
  always_comb begin
    dout        = {din[WIDTH-2:0], 1'b0};
    shifted_out = din[WIDTH-1];
    case (sel)
      SH_LSL, SH_ASL: begin
        dout        = {din[WIDTH-2:0], 1'b0};
        shifted_out = din[WIDTH-1];
      end
      SH_LSR: begin
        dout        = {1'b0, din[WIDTH-1:1]};
        shifted_out = din[0];
      end
      SH_ASR: begin
        dout        = {din[WIDTH-1], din[WIDTH-1:1]};
        shifted_out = din[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
// Optional carry_out port and register enabled by defining SHIFT_CARRY_EN.
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  state_t           state;
  logic [1:0]       sel_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] step_data;
  logic             step_out_bit;

  // Single shared one-position shifter; out_data doubles as the working register.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .sel         (sel_q),
    .din         (out_data),
    .dout        (step_data),
    .shifted_out (step_out_bit)
  );

`ifdef SHIFT_CARRY_EN
  // Last bit shifted out: cleared on acceptance, updated per step, held in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_out <= 1'b0;
    end else if (state == ST_IDLE && in_valid && in_ready) begin
      carry_out <= 1'b0;
    end else if (state == ST_SHIFT) begin
      carry_out <= step_out_bit;
    end
  end
`else
  logic unused_step_out_bit;
  assign unused_step_out_bit = step_out_bit;
`endif

  // Control FSM and datapath registers; every handshake output is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel_q     <= SH_LSL;
      cnt_q     <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            out_data <= in_data;
            sel_q    <= in_sel;
            cnt_q    <= in_amt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_amt == '0) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          out_data <= step_data;
          cnt_q    <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
